// File: rtl/ps2_scancode_filter.sv
// PS/2 Set-2 scan-code filter: strips E0/F0 prefixes, drops repeats and housekeeping
// bytes, and emits each new key press as a stretched keyIn strobe with stable key data.
module ps2_scancode_filter #(
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2Byte,
    input  logic       ps2ByteValid,
    output logic       keyIn,
    output logic [7:0] keyHexIn,
    output logic       keyExt,
    output logic       keyHeld,
    output logic       overflow
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        P_IDLE,
        P_PRE_E0,
        P_PRE_F0,
        P_PRE_E0F0,
        P_SKIP
    } p_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_HIGH,
        E_GAP
    } e_state_t;

    p_state_t        p_state;
    logic [2:0]      skip_cnt;
    logic [TO_W-1:0] to_cnt;

    e_state_t        e_state;
    logic [PC_W-1:0] pulse_cnt;
    logic            pend_valid;
    logic [7:0]      pend_code;
    logic            pend_ext;

    logic make_c;
    logic brk_c;
    logic ext_c;
    logic match_c;
    logic make_ok_c;
    logic brk_hit_c;

    // Classify the current byte as make / break for the parser state it arrives in
    always_comb begin
        make_c = 1'b0;
        brk_c  = 1'b0;
        ext_c  = 1'b0;
        if (ps2ByteValid) begin
            case (p_state)
                P_IDLE: begin
                    case (ps2Byte)
                        8'hE0, 8'hF0, 8'hE1: ;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: make_c = 1'b1;
                    endcase
                end
                P_PRE_E0: begin
                    if (ps2Byte != 8'hF0 && ps2Byte != 8'h12 && ps2Byte != 8'h59) begin
                        make_c = 1'b1;
                        ext_c  = 1'b1;
                    end
                end
                P_PRE_F0: begin
                    brk_c = 1'b1;
                end
                P_PRE_E0F0: begin
                    brk_c = 1'b1;
                    ext_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Compare against the last emitted key to detect repeats and its own release
    always_comb begin
        match_c   = ({ext_c, ps2Byte} == {keyExt, keyHexIn});
        make_ok_c = make_c && !(SUPPRESS_REPEAT && keyHeld && match_c);
        brk_hit_c = brk_c && match_c;
    end

    // Parser FSM: tracks prefixes, Pause-sequence skipping and the idle timeout
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p_state  <= P_IDLE;
            skip_cnt <= 3'd0;
            to_cnt   <= '0;
        end else if (ps2ByteValid) begin
            to_cnt <= '0;
            case (p_state)
                P_IDLE: begin
                    case (ps2Byte)
                        8'hE0: p_state <= P_PRE_E0;
                        8'hF0: p_state <= P_PRE_F0;
                        8'hE1: begin
                            p_state  <= P_SKIP;
                            skip_cnt <= 3'd7;
                        end
                        default: p_state <= P_IDLE;
                    endcase
                end
                P_PRE_E0: begin
                    if (ps2Byte == 8'hF0) begin
                        p_state <= P_PRE_E0F0;
                    end else begin
                        p_state <= P_IDLE;
                    end
                end
                P_SKIP: begin
                    if (skip_cnt <= 3'd1) begin
                        p_state <= P_IDLE;
                    end
                    skip_cnt <= skip_cnt - 3'd1;
                end
                default: p_state <= P_IDLE;
            endcase
        end else if (p_state != P_IDLE) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                p_state <= P_IDLE;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // Emitter FSM: stretched keyIn pulse, one-cycle gap, one-entry pending buffer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_state    <= E_IDLE;
            pulse_cnt  <= '0;
            pend_valid <= 1'b0;
            pend_code  <= 8'h00;
            pend_ext   <= 1'b0;
            keyIn      <= 1'b0;
            keyHexIn   <= 8'h00;
            keyExt     <= 1'b0;
            keyHeld    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (brk_hit_c) begin
                keyHeld <= 1'b0;
            end
            case (e_state)
                E_IDLE: begin
                    if (make_ok_c) begin
                        keyIn     <= 1'b1;
                        keyHexIn  <= ps2Byte;
                        keyExt    <= ext_c;
                        keyHeld   <= 1'b1;
                        pulse_cnt <= PC_W'(1);
                        e_state   <= E_HIGH;
                    end
                end
                E_HIGH: begin
                    if (pulse_cnt == PC_W'(PULSE_CYCLES)) begin
                        keyIn   <= 1'b0;
                        e_state <= E_GAP;
                    end else begin
                        pulse_cnt <= pulse_cnt + PC_W'(1);
                    end
                    if (make_ok_c) begin
                        overflow   <= pend_valid;
                        pend_valid <= 1'b1;
                        pend_code  <= ps2Byte;
                        pend_ext   <= ext_c;
                    end
                end
                E_GAP: begin
                    if (pend_valid) begin
                        keyIn     <= 1'b1;
                        keyHexIn  <= pend_code;
                        keyExt    <= pend_ext;
                        keyHeld   <= 1'b1;
                        pulse_cnt <= PC_W'(1);
                        e_state   <= E_HIGH;
                        if (make_ok_c) begin
                            pend_code <= ps2Byte;
                            pend_ext  <= ext_c;
                        end else begin
                            pend_valid <= 1'b0;
                        end
                    end else if (make_ok_c) begin
                        keyIn     <= 1'b1;
                        keyHexIn  <= ps2Byte;
                        keyExt    <= ext_c;
                        keyHeld   <= 1'b1;
                        pulse_cnt <= PC_W'(1);
                        e_state   <= E_HIGH;
                    end else begin
                        e_state <= E_IDLE;
                    end
                end
                default: e_state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Directed bench for ps2_scancode_filter: per-cycle vector table plus hand sequences.
module tb_ps2_scancode_filter;

    localparam int unsigned PC = 4;
    localparam int unsigned TO = 20;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] ps2Byte;
    logic       ps2ByteValid;

    logic       keyIn, keyExt, keyHeld, overflow;
    logic [7:0] keyHexIn;
    logic       keyIn2, keyExt2, keyHeld2, overflow2;
    logic [7:0] keyHexIn2;

    ps2_scancode_filter #(.PULSE_CYCLES(PC), .TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut (
        .clock(clock), .resetn(resetn), .ps2Byte(ps2Byte), .ps2ByteValid(ps2ByteValid),
        .keyIn(keyIn), .keyHexIn(keyHexIn), .keyExt(keyExt), .keyHeld(keyHeld), .overflow(overflow)
    );

    ps2_scancode_filter #(.PULSE_CYCLES(PC), .TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut2 (
        .clock(clock), .resetn(resetn), .ps2Byte(ps2Byte), .ps2ByteValid(ps2ByteValid),
        .keyIn(keyIn2), .keyHexIn(keyHexIn2), .keyExt(keyExt2), .keyHeld(keyHeld2), .overflow(overflow2)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic [7:0] b;
        logic       k;
        logic [7:0] hex;
        logic       ext;
        logic       held;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Rising-edge counters for both instances, sampled on the falling edge
    int   rises = 0;
    int   rises2 = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clock) begin
        if (keyIn && !prev1) rises = rises + 1;
        if (keyIn2 && !prev2) rises2 = rises2 + 1;
        prev1 = keyIn;
        prev2 = keyIn2;
    end

    function automatic void add(logic v, logic [7:0] b, logic k, logic [7:0] h,
                                logic e, logic hd, logic o);
        vec_t r;
        r.v = v; r.b = b; r.k = k; r.hex = h; r.ext = e; r.held = hd; r.ovf = o;
        tbl.push_back(r);
    endfunction

    function automatic void idle(int n, logic k, logic [7:0] h, logic e, logic hd);
        for (int i = 0; i < n; i++) add(1'b0, 8'h00, k, h, e, hd, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2Byte      = b;
        ps2ByteValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ps2ByteValid = 1'b0;
        ps2Byte      = 8'h00;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        ps2ByteValid = 1'b0;
        ps2Byte      = 8'h00;
        resetn       = 1'b0;
        wait_cycles(2);
        resetn = 1'b1;
        wait_cycles(1);
    endtask

    logic [7:0] pause_seq [8];
    int         r1, r2;

    initial begin
        resetn       = 1'b0;
        ps2ByteValid = 1'b0;
        ps2Byte      = 8'h00;

        // Reset state
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Single make, then its break
        add(1'b1, 8'h16, 1'b1, 8'h16, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 8'h16, 1'b0, 1'b1);
        idle(3, 1'b0, 8'h16, 1'b0, 1'b1);
        add(1'b1, 8'hF0, 1'b0, 8'h16, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h16, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0, 8'h16, 1'b0, 1'b0);
        // Typematic repeats suppressed
        add(1'b1, 8'h16, 1'b1, 8'h16, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 8'h16, 1'b0, 1'b1);
        idle(2, 1'b0, 8'h16, 1'b0, 1'b1);
        add(1'b1, 8'h16, 1'b0, 8'h16, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0, 8'h16, 1'b0, 1'b1);
        add(1'b1, 8'h16, 1'b0, 8'h16, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0, 8'h16, 1'b0, 1'b1);
        add(1'b1, 8'hF0, 1'b0, 8'h16, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h16, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0, 8'h16, 1'b0, 1'b0);
        // Extended make, non-extended break ignored, extended break, fake shift
        add(1'b1, 8'hE0, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 8'h5A, 1'b1, 1'b1);
        idle(2, 1'b0, 8'h5A, 1'b1, 1'b1);
        add(1'b1, 8'hF0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        add(1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        add(1'b1, 8'hE0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        add(1'b1, 8'hF0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        add(1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0, 8'h5A, 1'b1, 1'b0);
        add(1'b1, 8'hE0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h12, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0, 8'h5A, 1'b1, 1'b0);
        // Back-to-back makes: 72 overwritten by 7A, overflow pulse
        add(1'b1, 8'h69, 1'b1, 8'h69, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h72, 1'b1, 8'h69, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h7A, 1'b1, 8'h69, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1, 8'h69, 1'b0, 1'b1);
        idle(1, 1'b0, 8'h69, 1'b0, 1'b1);
        idle(4, 1'b1, 8'h7A, 1'b0, 1'b1);
        idle(2, 1'b0, 8'h7A, 1'b0, 1'b1);
        // Break during own pulse; make landing in the gap loads directly
        add(1'b1, 8'h33, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'hF0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1, 8'h33, 1'b0, 1'b0);
        idle(1, 1'b0, 8'h33, 1'b0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 8'h44, 1'b0, 1'b1);
        idle(2, 1'b0, 8'h44, 1'b0, 1'b1);

        @(negedge clock);
        chk("reset_keyIn", 32'(keyIn), 32'd0);
        chk("reset_keyHexIn", 32'(keyHexIn), 32'd0);
        wait_cycles(1);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            ps2ByteValid = tbl[i].v;
            ps2Byte      = tbl[i].b;
            @(posedge clock);
            @(negedge clock);
            checks = checks + 1;
            if ({keyIn, keyHexIn, keyExt, keyHeld, overflow} !==
                {tbl[i].k, tbl[i].hex, tbl[i].ext, tbl[i].held, tbl[i].ovf}) begin
                errors = errors + 1;
                $display("FAIL row%0d: got k=%b hex=%h ext=%b held=%b ovf=%b expected k=%b hex=%h ext=%b held=%b ovf=%b",
                         i, keyIn, keyHexIn, keyExt, keyHeld, overflow,
                         tbl[i].k, tbl[i].hex, tbl[i].ext, tbl[i].held, tbl[i].ovf);
            end
        end
        ps2ByteValid = 1'b0;
        ps2Byte      = 8'h00;

        // Repeat handling: one pulse with suppression, three without
        do_reset();
        r1 = rises;
        r2 = rises2;
        send(8'h16); wait_cycles(9);
        send(8'h16); wait_cycles(9);
        send(8'h16); wait_cycles(9);
        send(8'hF0); wait_cycles(2);
        send(8'h16); wait_cycles(6);
        chk("repeat_suppressed_pulses", 32'(rises - r1), 32'd1);
        chk("repeat_allowed_pulses", 32'(rises2 - r2), 32'd3);
        chk("repeat_allowed_released", 32'(keyHeld2), 32'd0);

        // Pause sequence swallowed, then parser back in IDLE
        do_reset();
        pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77; pause_seq[3] = 8'hE1;
        pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14; pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;
        r1 = rises;
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            wait_cycles(2);
        end
        wait_cycles(5);
        chk("pause_no_emit", 32'(rises - r1), 32'd0);
        send(8'h16);
        chk("after_pause_keyIn", 32'(keyIn), 32'd1);
        chk("after_pause_hex", 32'(keyHexIn), 32'h16);
        wait_cycles(8);

        // F0 with one cycle short of timeout: 70 is still a break
        r1 = rises;
        send(8'hF0);
        wait_cycles(TO - 1);
        send(8'h70);
        wait_cycles(6);
        chk("pre_timeout_break", 32'(rises - r1), 32'd0);
        chk("pre_timeout_held", 32'(keyHeld), 32'd1);

        // F0 with full timeout: 70 becomes a make
        send(8'hF0);
        wait_cycles(TO);
        send(8'h70);
        chk("timeout_make_keyIn", 32'(keyIn), 32'd1);
        chk("timeout_make_hex", 32'(keyHexIn), 32'h70);
        wait_cycles(8);

        // Asynchronous reset mid-pulse with a pending key
        do_reset();
        send(8'h69);
        send(8'h72);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_keyIn", 32'(keyIn), 32'd0);
        chk("async_rst_hex", 32'(keyHexIn), 32'd0);
        chk("async_rst_ext", 32'(keyExt), 32'd0);
        chk("async_rst_held", 32'(keyHeld), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        wait_cycles(1);
        r1 = rises;
        wait_cycles(12);
        chk("pending_discarded", 32'(rises - r1), 32'd0);
        send(8'h4D);
        chk("post_rst_keyIn", 32'(keyIn), 32'd1);
        chk("post_rst_hex", 32'(keyHexIn), 32'h4D);
        chk("post_rst_ext", 32'(keyExt), 32'd0);
        chk("post_rst_held", 32'(keyHeld), 32'd1);
        wait_cycles(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
